// File: rtl/dac_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dac_channel_arbiter
// Description : Shares one serial 4-channel DAC between two 8-bit valid/ready
//               sample producers. The winner's word {A[1:0], RNG, D[7:0]} is
//               shifted out MSB first on a clk-derived DACclk. A LOAD pulse
//               follows, then a gap before the next frame.
//               Optional feature macro: DAC_ARB_RR_EN (round-robin on ties;
//               fixed priority to requester 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module dac_channel_arbiter #(
    parameter int         CLK_DIV  = 4,
    parameter logic       RNG_BIT  = 1'b0,
    parameter logic [1:0] CH0_ADDR = 2'b00,
    parameter logic [1:0] CH1_ADDR = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       DACclk,
    output logic       DACserial,
    output logic       load,
    output logic       LDAC,
    output logic       busy,
    output logic       grant
);

    localparam int              c_CW       = $clog2(CLK_DIV) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [3:0]      c_BIT_LAST = 4'd10;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit;
    logic            r_phase;      // 0: DACclk high half of slot, 1: low half
    logic [9:0]      r_shreg;      // bits still to be sent after the current one
    logic            r_dacclk;
    logic            r_serial;
    logic            r_load;
    logic            r_busy;
    logic            r_grant;

    logic            w_sel;
    logic            w_idle;
    logic            w_xfer;
    logic [10:0]     w_word;

    // Ready is only offered in IDLE and never while reset is asserted
    assign w_idle     = (r_state == c_ST_IDLE) && !reset;
    assign req0_ready = w_idle && !w_sel && req0_valid;
    assign req1_ready = w_idle &&  w_sel && req1_valid;
    assign w_xfer     = req0_ready || req1_ready;
    assign w_word     = w_sel ? {CH1_ADDR, RNG_BIT, req1_data}
                              : {CH0_ADDR, RNG_BIT, req0_data};

`ifdef DAC_ARB_RR_EN
    logic r_last;

    // Remember the most recent winner so a tie goes to the other requester
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_xfer) begin
            r_last <= w_sel;
        end
    end

    // Select requester: a lone valid wins, a tie goes to the one not served last
    always_comb begin
        w_sel = req1_valid && !req0_valid;
        if (req0_valid && req1_valid) begin
            w_sel = ~r_last;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is not asking
    assign w_sel = req1_valid && !req0_valid;
`endif

    // Frame sequencer: capture, shift 11 slots, pulse LOAD, then a gap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_phase  <= 1'b0;
            r_shreg  <= '0;
            r_dacclk <= 1'b0;
            r_serial <= 1'b0;
            r_load   <= 1'b1;
            r_busy   <= 1'b0;
            r_grant  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_xfer) begin
                        r_state  <= c_ST_SHIFT;
                        r_shreg  <= w_word[9:0];
                        r_serial <= w_word[10];
                        r_dacclk <= 1'b1;
                        r_cnt    <= '0;
                        r_bit    <= 4'd0;
                        r_phase  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_grant  <= w_sel;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            // falling edge mid-slot: the DAC latches r_serial here
                            r_phase  <= 1'b1;
                            r_dacclk <= 1'b0;
                        end else if (r_bit == c_BIT_LAST) begin
                            r_state  <= c_ST_LOAD;
                            r_load   <= 1'b0;
                            r_serial <= 1'b0;
                        end else begin
                            r_bit    <= r_bit + 4'd1;
                            r_phase  <= 1'b0;
                            r_dacclk <= 1'b1;
                            r_serial <= r_shreg[9];
                            r_shreg  <= {r_shreg[8:0], 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_LOAD: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_load  <= 1'b1;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_GAP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign DACclk    = r_dacclk;
    assign DACserial = r_serial;
    assign load      = r_load;
    assign LDAC      = 1'b0;
    assign busy      = r_busy;
    assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_dac_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_channel_arbiter
// Description : Self-checking bench for dac_channel_arbiter (CLK_DIV=4).
//               Frames on the serial pins are decoded and compared against a
//               queue of expected words pushed when each transfer is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_channel_arbiter;

    localparam int C     = 4;
    localparam int FRAME = 24 * C + 1;
`ifdef DAC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       DACclk, DACserial, load, LDAC, busy, grant;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [10:0] exp_q[$];

    typedef struct packed {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       win_fp;
        logic       win_rr;
    } vec_t;

    vec_t vecs[8];

    dac_channel_arbiter #(
        .CLK_DIV  (C),
        .RNG_BIT  (1'b0),
        .CH0_ADDR (2'b00),
        .CH1_ADDR (2'b01)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .DACclk     (DACclk),
        .DACserial  (DACserial),
        .load       (load),
        .LDAC       (LDAC),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [10:0] mk(input logic w, input logic [7:0] a, input logic [7:0] b);
        return w ? {2'b01, 1'b0, b} : {2'b00, 1'b0, a};
    endfunction

    // Wait (bounded) for the negedge on which a ready is offered
    task automatic wait_xfer(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_ready || req1_ready) && n < 300);
        if (!(req0_ready || req1_ready)) chk({nm, " transfer timeout"}, 32'd0, 32'd1);
    endtask

    // Serial-frame monitor: decode bits at DACclk falling edges, score at LOAD
    logic        prev_clk, prev_load;
    logic [10:0] rx;
    int          rx_n, low_len;
    always @(negedge clk) begin
        if (reset) begin
            prev_clk  = 1'b0;
            prev_load = 1'b1;
            rx        = '0;
            rx_n      = 0;
            low_len   = 0;
        end else begin
            if (prev_clk && !DACclk) begin
                rx = {rx[9:0], DACserial};
                rx_n++;
            end
            if (prev_load && !load) begin
                chk("bits before load", rx_n, 11);
                if (exp_q.size() == 0) chk("load with no frame pending", exp_q.size(), 1);
                else chk("frame word", rx, exp_q.pop_front());
                rx_n    = 0;
                low_len = 0;
            end
            if (!load) low_len++;
            if (!prev_load && load) chk("load low length", low_len, C);
            prev_clk  = DACclk;
            prev_load = load;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t_prev, t_now;
        logic win, hold_ok;

        //                v0    v1    d0     d1     fp    rr
        vecs[0] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1};

        // Reset with a valid already pending: no ready, all outputs at reset values
        reset = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5;
        req1_valid = 1'b0; req1_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset req0_ready", req0_ready, 0);
        chk("reset req1_ready", req1_ready, 0);
        chk("reset DACclk", DACclk, 0);
        chk("reset DACserial", DACserial, 0);
        chk("reset load", load, 1);
        chk("reset LDAC", LDAC, 0);
        chk("reset busy", busy, 0);
        chk("reset grant", grant, 0);

        // Single frame of 8'hA5 from requester 0
        @(posedge clk); #1 reset = 1'b0;
        wait_xfer("single");
        chk("single ready0", req0_ready, 1);
        chk("single ready1", req1_ready, 0);
        exp_q.push_back(mk(1'b0, 8'hA5, 8'h00));
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk); #1;
            if (k == 2) req0_valid = 1'b0;
            @(negedge clk);
            case (k)
                1: begin
                    chk("single ready0 one pulse", req0_ready, 0);
                    chk("single DACclk first rise", DACclk, 1);
                    chk("single busy set", busy, 1);
                    chk("single first bit A1", DACserial, 0);
                end
                C:          chk("single DACclk high half", DACclk, 1);
                C + 1:      chk("single DACclk first fall", DACclk, 0);
                22 * C:     chk("single load before LOAD", load, 1);
                22 * C + 1: chk("single load falls", load, 0);
                23 * C:     chk("single load last low", load, 0);
                23 * C + 1: chk("single load back high", load, 1);
                24 * C:     chk("single busy in GAP", busy, 1);
                24 * C + 1: chk("single busy clear", busy, 0);
                default: ;
            endcase
        end

        // Hold-off: requester 1 asks 10 cycles into a requester-0 frame
        @(posedge clk); #1 req0_valid = 1'b1; req0_data = 8'h3C;
        wait_xfer("holdoff r0");
        exp_q.push_back(mk(1'b0, 8'h3C, 8'h00));
        hold_ok = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk); #1;
            if (k == 1) req0_valid = 1'b0;
            if (k == 10) begin req1_valid = 1'b1; req1_data = 8'hC6; end
            @(negedge clk);
            if (k < FRAME && req1_ready) hold_ok = 1'b0;
            if (k == FRAME) chk("holdoff ready1 at T+97", req1_ready, 1);
        end
        chk("holdoff ready1 low during frame", hold_ok, 1);
        exp_q.push_back(mk(1'b1, 8'h00, 8'hC6));
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        chk("holdoff grant", grant, 1);
        repeat (FRAME + 5) @(negedge clk);

        // Reset mid-frame: requester-1 frame abandoned, requester 0 served at once
        @(posedge clk); #1 req1_valid = 1'b1; req1_data = 8'h77;
        wait_xfer("abort r1");
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            if (k == 1) req1_valid = 1'b0;
            if (k == 30) begin reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h9B; end
            if (k == 31) reset = 1'b0;
            @(negedge clk);
            if (k == 29) chk("abort grant before reset", grant, 1);
            if (k == 30) chk("no ready during reset", {req0_ready, req1_ready}, 0);
            if (k == 31) begin
                chk("abort DACclk", DACclk, 0);
                chk("abort load", load, 1);
                chk("abort busy", busy, 0);
                chk("abort grant", grant, 0);
                chk("ready0 right after reset", req0_ready, 1);
            end
        end
        exp_q.push_back(mk(1'b0, 8'h9B, 8'h00));
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (FRAME + 5) @(negedge clk);

        // Fresh reset so the round-robin pointer starts from a known value
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // Table: arbitration, tie handling, back-to-back spacing, data capture
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
            wait_xfer("vec");
            t_now = cyc;
            win = RR ? vecs[i].win_rr : vecs[i].win_fp;
            chk("vec ready0", req0_ready, (win == 1'b0 && vecs[i].v0) ? 1 : 0);
            chk("vec ready1", req1_ready, (win == 1'b1 && vecs[i].v1) ? 1 : 0);
            exp_q.push_back(mk(win, vecs[i].d0, vecs[i].d1));
            if (i > 0) chk("vec transfer spacing", t_now - t_prev, FRAME);
            t_prev = t_now;
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_data = ~req0_data; req1_data = ~req1_data;
            @(negedge clk);
            chk("vec grant", grant, win);
        end

        repeat (FRAME + 10) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
